// File: rtl/sync_updown_counter_pkg.sv
// Shared definitions for loadable counters: direction encoding
// and the load-value clamp reused by other modulo counters.
package sync_updown_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int clamp_mod(input int value, input int mod);
        return (value > mod - 1) ? mod - 1 : value;
    endfunction

endpackage

// File: rtl/sync_updown_counter_bin2gray.sv
// Combinational binary-to-Gray converter; the caller registers it.
// Used by sync_updown_counter only when GRAY_OUT_EN is defined.
module bin2gray #(
    parameter int N = 4
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-MOD up/down counter with clamped load and wrap pulse.
// Define GRAY_OUT_EN to add the registered Gray-coded output q_gray.
module sync_updown_counter
    import sync_updown_counter_pkg::*;
#(
    parameter int N   = 4,
    parameter int MOD = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         wrap
`ifdef GRAY_OUT_EN
    ,
    output logic [N-1:0] q_gray
`endif
);

    localparam logic [N:0] MOD_X = (N+1)'(MOD);
    localparam logic [N:0] LAST  = (N+1)'(MOD - 1);

    logic [N:0]   q_x;
    logic [N:0]   inc;
    logic [N:0]   dec;
    logic         at_max;
    logic         at_zero;
    logic [N-1:0] q_next;
    logic         wrap_next;

    assign q_x = {1'b0, q};
    assign inc = q_x + (N+1)'(1);
    assign dec = q_x - (N+1)'(1);

    // The extra bit catches both edges: inc reaching MOD, dec borrowing below 0.
    assign at_max  = (inc == MOD_X);
    assign at_zero = dec[N];

    assign tc = (up == DIR_UP) ? at_max : at_zero;

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = N'(clamp_mod(int'(d), MOD));
        end else if (en) begin
            if (up == DIR_UP) begin
                q_next    = at_max ? '0 : inc[N-1:0];
                wrap_next = at_max;
            end else begin
                q_next    = at_zero ? LAST[N-1:0] : dec[N-1:0];
                wrap_next = at_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

`ifdef GRAY_OUT_EN
    logic [N-1:0] gray_next;

    bin2gray #(.N(N)) u_bin2gray (
        .bin  (q_next),
        .gray (gray_next)
    );

    // Encoding the next value keeps q_gray in the same cycle as q.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_gray <= '0;
        end else begin
            q_gray <= gray_next;
        end
    end
`endif

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench for sync_updown_counter (N=4, MOD=10).
// Define GRAY_OUT_EN to also check q_gray.
module tb_sync_updown_counter;

    localparam int N   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         tc;
    logic         wrap;
`ifdef GRAY_OUT_EN
    logic [N-1:0] q_gray;
`endif

    int   mq;
    logic mwrap;
    int   passed = 0;
    int   total  = 0;

    always #10 clk = ~clk;

    sync_updown_counter #(.N(N), .MOD(MOD)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .up    (up),
        .load  (load),
        .d     (d),
        .q     (q),
        .tc    (tc),
        .wrap  (wrap)
`ifdef GRAY_OUT_EN
        ,
        .q_gray(q_gray)
`endif
    );

    // Reference: modular arithmetic straight from the counting rules.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            mq = 0;
            mwrap = 1'b0;
        end else if (load) begin
            mq = (int'(d) >= MOD) ? MOD - 1 : int'(d);
            mwrap = 1'b0;
        end else if (en && up) begin
            mwrap = (mq + 1 == MOD);
            mq = (mq + 1) % MOD;
        end else if (en) begin
            mwrap = (mq == 0);
            mq = (mq + MOD - 1) % MOD;
        end else begin
            mwrap = 1'b0;
        end
        #1;
    endtask

    function automatic logic exp_tc();
        return (up && mq == MOD - 1) || (!up && mq == 0);
    endfunction

    task automatic test_reset();
        reset = 1; en = 0; up = 0; load = 0; d = 0;
        tick();
        tick();
        total++;
        if (q !== 4'd0) $display("FAIL reset_q q=%0d exp=0", q);
        else passed++;
        total++;
        if (wrap !== 1'b0) $display("FAIL reset_wrap wrap=%b exp=0", wrap);
        else passed++;
        total++;
        if (tc !== 1'b1) $display("FAIL reset_tc_dn tc=%b exp=1", tc);
        else passed++;
`ifdef GRAY_OUT_EN
        total++;
        if (q_gray !== 4'd0) $display("FAIL reset_gray g=%b exp=0", q_gray);
        else passed++;
`endif
        up = 1;
        #1;
        total++;
        if (tc !== 1'b0) $display("FAIL reset_tc_up tc=%b exp=0", tc);
        else passed++;
        reset = 0;
    endtask

    task automatic test_count_up();
        int exp_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int wraps = 0;
        en = 1; up = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (q !== exp_q[i][N-1:0])
                $display("FAIL up_q i=%0d q=%0d exp=%0d", i, q, exp_q[i]);
            else passed++;
            total++;
            if (wrap !== mwrap)
                $display("FAIL up_wrap i=%0d wrap=%b exp=%b", i, wrap, mwrap);
            else passed++;
            total++;
            if (tc !== (exp_q[i] == 9))
                $display("FAIL up_tc i=%0d tc=%b q=%0d", i, tc, q);
            else passed++;
`ifdef GRAY_OUT_EN
            total++;
            if (q_gray !== 4'(mq ^ (mq >> 1)))
                $display("FAIL up_gray i=%0d g=%b q=%0d", i, q_gray, q);
            else passed++;
`endif
            if (wrap === 1'b1) wraps++;
        end
        total++;
        if (wraps != 1) $display("FAIL up_wrap_count got=%0d exp=1", wraps);
        else passed++;
    endtask

    task automatic test_count_down();
        int exp_q[3] = '{9, 8, 7};
        en = 0; load = 1; d = 0;
        tick();
        load = 0; en = 1; up = 0;
        #1;
        total++;
        if (tc !== 1'b1) $display("FAIL dn_tc_zero tc=%b exp=1", tc);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (q !== exp_q[i][N-1:0])
                $display("FAIL dn_q i=%0d q=%0d exp=%0d", i, q, exp_q[i]);
            else passed++;
            total++;
            if (wrap !== (i == 0))
                $display("FAIL dn_wrap i=%0d wrap=%b", i, wrap);
            else passed++;
        end
    endtask

    task automatic test_load();
        int exp_q[3] = '{6, 6, 7};
        logic en_seq[3] = '{1'b1, 1'b0, 1'b1};
        up = 1; en = 1; load = 1; d = 4'd13;
        tick();
        total++;
        if (q !== 4'd9) $display("FAIL load_clamp q=%0d exp=9", q);
        else passed++;
        total++;
        if (wrap !== 1'b0) $display("FAIL load_wrap wrap=%b exp=0", wrap);
        else passed++;
        d = 4'd5;
        tick();
        total++;
        if (q !== 4'd5) $display("FAIL load_5 q=%0d exp=5", q);
        else passed++;
        load = 0;
        for (int i = 0; i < 3; i++) begin
            en = en_seq[i];
            tick();
            total++;
            if (q !== exp_q[i][N-1:0])
                $display("FAIL en_toggle i=%0d q=%0d exp=%0d", i, q, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int exp_q[3] = '{4, 3, 2};
        en = 0; load = 1; d = 4'd2;
        tick();
        load = 0; en = 1; up = 1;
        tick();
        total++;
        if (q !== 4'd3) $display("FAIL flip_start q=%0d exp=3", q);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            up = (i == 0);
            tick();
            total++;
            if (q !== exp_q[i][N-1:0])
                $display("FAIL flip_q i=%0d q=%0d exp=%0d", i, q, exp_q[i]);
            else passed++;
        end
        reset = 1; load = 1; d = 4'd7; en = 1;
        tick();
        total++;
        if (q !== 4'd0) $display("FAIL reset_over_load q=%0d exp=0", q);
        else passed++;
        reset = 0; load = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(31) == 0);
            load  = ($urandom_range(7) == 0);
            en    = ($urandom_range(3) != 0);
            up    = $urandom_range(1);
            d     = 4'($urandom_range(15));
            tick();
            total++;
            if (q !== mq[N-1:0] || wrap !== mwrap || tc !== exp_tc())
                $display("FAIL rand i=%0d q=%0d w=%b tc=%b exp q=%0d w=%b tc=%b",
                         i, q, wrap, tc, mq, mwrap, exp_tc());
            else passed++;
            total++;
            if (int'(q) >= MOD) $display("FAIL rand_range i=%0d q=%0d", i, q);
            else passed++;
`ifdef GRAY_OUT_EN
            total++;
            if (q_gray !== 4'(mq ^ (mq >> 1)))
                $display("FAIL rand_gray i=%0d g=%b q=%0d", i, q_gray, q);
            else passed++;
`endif
        end
    endtask

    initial begin
        mq = 0;
        mwrap = 1'b0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
